// File: rtl/fractal_sync_pkg.sv
// Shared types and helpers for the fractal sync arbiter: pending-slot payload
// and port-index width computation.
package fractal_sync_pkg;

  localparam int unsigned SLOT_AGGR_MAX = 32;
  localparam int unsigned SLOT_ID_MAX   = 32;
  localparam int unsigned SLOT_SD_MAX   = 32;

  // Slot fields are sized for the widest supported configuration and
  // narrowed at the point of use.
  typedef struct packed {
    logic                     valid;
    logic [SLOT_AGGR_MAX-1:0] aggr;
    logic [SLOT_ID_MAX-1:0]   id;
    logic [SLOT_SD_MAX-1:0]   src;
  } slot_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fractal_if.sv
// Sync/wake link between fractal sync tree nodes: requests flow up
// (sync/aggr/id/src), responses flow down (wake/dst/error).
interface fractal_if #(
  parameter int unsigned AGGR_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned SD_WIDTH   = 2
);
  logic                  sync;
  logic [AGGR_WIDTH-1:0] aggr;
  logic [ID_WIDTH-1:0]   id;
  logic [SD_WIDTH-1:0]   src;
  logic                  wake;
  logic [SD_WIDTH-1:0]   dst;
  logic                  error;

  modport mst_port (output sync, aggr, id, src, input  wake, dst, error);
  modport slv_port (input  sync, aggr, id, src, output wake, dst, error);
endinterface

// File: rtl/fractal_sync_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N.
module fractal_sync_rr_arb #(
  parameter int unsigned N         = 4,
  parameter int unsigned IDX_WIDTH = 2
) (
  input  logic [N-1:0]         req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic                 gnt_valid_c,
  output logic [IDX_WIDTH-1:0] gnt_idx_c
);

  function automatic logic [IDX_WIDTH-1:0] wrap_idx(input logic [IDX_WIDTH-1:0] base,
                                                    input int unsigned k);
    return IDX_WIDTH'((32'(base) + k) % N);
  endfunction

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    gnt_valid_c = 1'b0;
    gnt_idx_c   = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (req[wrap_idx(ptr, N - 1 - j)]) begin
        gnt_valid_c = 1'b1;
        gnt_idx_c   = wrap_idx(ptr, N - 1 - j);
      end
    end
  end

endmodule

// File: rtl/fractal_sync_arbiter.sv
// Merges N upstream sync requesters onto one downstream port with one pending
// slot per requester, and routes downstream wake/error back to the addressed port.
module fractal_sync_arbiter
  import fractal_sync_pkg::*;
#(
  parameter int unsigned N_PORTS    = 4,
  parameter int unsigned AGGR_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned SD_WIDTH   = 2,
  parameter int unsigned IDX_WIDTH  = idx_width(N_PORTS)
) (
  input logic         clk_i,
  input logic         rst_i,
  fractal_if.slv_port slv_ports [N_PORTS],
  fractal_if.mst_port mst_port
);

  localparam int unsigned DW = SD_WIDTH + IDX_WIDTH;

  logic [N_PORTS-1:0]    up_sync;
  logic [AGGR_WIDTH-1:0] up_aggr [N_PORTS];
  logic [ID_WIDTH-1:0]   up_id   [N_PORTS];
  logic [SD_WIDTH-1:0]   up_src  [N_PORTS];

  slot_t slot_q [N_PORTS];
  slot_t slot_d [N_PORTS];
  slot_t gnt_slot_c;

  logic [N_PORTS-1:0]   req;
  logic [N_PORTS-1:0]   gnt_oh;
  logic [N_PORTS-1:0]   overflow_c;
  logic [IDX_WIDTH-1:0] rr_q;
  logic [IDX_WIDTH-1:0] gnt_idx_c;
  logic                 gnt_valid_c;

  logic                  msync_q;
  logic [AGGR_WIDTH-1:0] maggr_q;
  logic [ID_WIDTH-1:0]   mid_q;
  logic [DW-1:0]         msrc_q;

  logic                 dn_wake;
  logic                 dn_error;
  logic [DW-1:0]        dn_dst;
  logic [IDX_WIDTH-1:0] dn_port;
  logic [SD_WIDTH-1:0]  dn_sub;
  logic [N_PORTS-1:0]   dn_hit;

  logic [N_PORTS-1:0]  wake_q;
  logic [N_PORTS-1:0]  error_q;
  logic [SD_WIDTH-1:0] dst_q [N_PORTS];

  // Flatten the interface array into plain vectors.
  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    assign up_sync[i]         = slv_ports[i].sync;
    assign up_aggr[i]         = slv_ports[i].aggr;
    assign up_id[i]           = slv_ports[i].id;
    assign up_src[i]          = slv_ports[i].src;
    assign slv_ports[i].wake  = wake_q[i];
    assign slv_ports[i].dst   = dst_q[i];
    assign slv_ports[i].error = error_q[i];
    assign req[i]             = slot_q[i].valid;
    assign gnt_oh[i]          = gnt_valid_c && (gnt_idx_c == IDX_WIDTH'(i));
    assign dn_hit[i]          = (dn_port == IDX_WIDTH'(i));
  end

  assign mst_port.sync = msync_q;
  assign mst_port.aggr = maggr_q;
  assign mst_port.id   = mid_q;
  assign mst_port.src  = msrc_q;
  assign dn_wake       = mst_port.wake;
  assign dn_error      = mst_port.error;
  assign dn_dst        = mst_port.dst;
  assign dn_port       = dn_dst[DW-1:SD_WIDTH];
  assign dn_sub        = dn_dst[SD_WIDTH-1:0];

  fractal_sync_rr_arb #(
    .N         (N_PORTS),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_rr_arb (
    .req         (req),
    .ptr         (rr_q),
    .gnt_valid_c (gnt_valid_c),
    .gnt_idx_c   (gnt_idx_c)
  );

  assign gnt_slot_c = slot_q[gnt_idx_c];

  // A slot being granted this cycle is free to accept a new sync.
  always_comb begin
    overflow_c = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      slot_d[i] = slot_q[i];
      if (up_sync[i] && (!slot_q[i].valid || gnt_oh[i])) begin
        slot_d[i].valid = 1'b1;
        slot_d[i].aggr  = SLOT_AGGR_MAX'(up_aggr[i]);
        slot_d[i].id    = SLOT_ID_MAX'(up_id[i]);
        slot_d[i].src   = SLOT_SD_MAX'(up_src[i]);
      end else begin
        overflow_c[i] = up_sync[i];
        if (gnt_oh[i]) slot_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        slot_q[i] <= '0;
        dst_q[i]  <= '0;
      end
      rr_q    <= '0;
      msync_q <= 1'b0;
      maggr_q <= '0;
      mid_q   <= '0;
      msrc_q  <= '0;
      wake_q  <= '0;
      error_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        slot_q[i]  <= slot_d[i];
        wake_q[i]  <= dn_wake && dn_hit[i];
        dst_q[i]   <= (dn_wake && dn_hit[i]) ? dn_sub : '0;
        error_q[i] <= (dn_error && dn_hit[i]) || overflow_c[i];
      end
      if (gnt_valid_c) begin
        rr_q <= (32'(gnt_idx_c) == N_PORTS - 1) ? '0 : gnt_idx_c + IDX_WIDTH'(1);
      end
      msync_q <= gnt_valid_c;
      maggr_q <= gnt_valid_c ? AGGR_WIDTH'(gnt_slot_c.aggr) : '0;
      mid_q   <= gnt_valid_c ? ID_WIDTH'(gnt_slot_c.id) : '0;
      msrc_q  <= gnt_valid_c ? {gnt_idx_c, SD_WIDTH'(gnt_slot_c.src)} : '0;
    end
  end

endmodule

// File: tb/tb_fractal_sync_arbiter.sv
// Directed and randomized checks of fractal_sync_arbiter against a
// cycle-level behavioural model of the pending slots and round-robin order.
module tb_fractal_sync_arbiter;

  localparam int unsigned NP  = 4;
  localparam int unsigned AW  = 8;
  localparam int unsigned IW  = 4;
  localparam int unsigned SW  = 2;
  localparam int unsigned DW  = SW + 2;
  localparam int unsigned ADW = SW + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Main DUT stimulus/observation
  logic [NP-1:0] s_sync;
  logic [AW-1:0] s_aggr [NP];
  logic [IW-1:0] s_id   [NP];
  logic [SW-1:0] s_src  [NP];
  logic          d_wake, d_err;
  logic [DW-1:0] d_dst;
  logic [NP-1:0] o_wake, o_err;
  logic [SW-1:0] o_dst [NP];

  // Auxiliary DUT with a wider index field, so out-of-range ports are expressible
  logic           a_wake, a_err;
  logic [ADW-1:0] a_dst;
  logic [NP-1:0]  ao_wake, ao_err;
  logic [SW-1:0]  ao_dst [NP];

  fractal_if #(.AGGR_WIDTH(AW), .ID_WIDTH(IW), .SD_WIDTH(SW))  up  [NP] ();
  fractal_if #(.AGGR_WIDTH(AW), .ID_WIDTH(IW), .SD_WIDTH(DW))  dn ();
  fractal_if #(.AGGR_WIDTH(AW), .ID_WIDTH(IW), .SD_WIDTH(SW))  aup [NP] ();
  fractal_if #(.AGGR_WIDTH(AW), .ID_WIDTH(IW), .SD_WIDTH(ADW)) adn ();

  fractal_sync_arbiter #(
    .N_PORTS(NP), .AGGR_WIDTH(AW), .ID_WIDTH(IW), .SD_WIDTH(SW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .slv_ports(up), .mst_port(dn)
  );

  fractal_sync_arbiter #(
    .N_PORTS(NP), .AGGR_WIDTH(AW), .ID_WIDTH(IW), .SD_WIDTH(SW), .IDX_WIDTH(3)
  ) dut_aux (
    .clk_i(clk), .rst_i(rst), .slv_ports(aup), .mst_port(adn)
  );

  for (genvar i = 0; i < NP; i++) begin : g_up
    assign up[i].sync  = s_sync[i];
    assign up[i].aggr  = s_aggr[i];
    assign up[i].id    = s_id[i];
    assign up[i].src   = s_src[i];
    assign o_wake[i]   = up[i].wake;
    assign o_dst[i]    = up[i].dst;
    assign o_err[i]    = up[i].error;
    assign aup[i].sync = 1'b0;
    assign aup[i].aggr = '0;
    assign aup[i].id   = '0;
    assign aup[i].src  = '0;
    assign ao_wake[i]  = aup[i].wake;
    assign ao_dst[i]   = aup[i].dst;
    assign ao_err[i]   = aup[i].error;
  end

  assign dn.wake   = d_wake;
  assign dn.dst    = d_dst;
  assign dn.error  = d_err;
  assign adn.wake  = a_wake;
  assign adn.dst   = a_dst;
  assign adn.error = a_err;

  // Reference model state: one pending entry per port and the search start
  bit            m_v [NP];
  logic [AW-1:0] m_a [NP];
  logic [IW-1:0] m_i [NP];
  logic [SW-1:0] m_s [NP];
  int            m_rr;

  logic          e_sync;
  logic [AW-1:0] e_aggr;
  logic [IW-1:0] e_id;
  logic [DW-1:0] e_src;
  logic [NP-1:0] e_wake, e_err;
  logic [SW-1:0] e_dst [NP];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) m_v[i] = 1'b0;
    m_rr = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".sync"}, 32'(dn.sync), 32'(e_sync));
    chk({tag, ".aggr"}, 32'(dn.aggr), 32'(e_aggr));
    chk({tag, ".id"},   32'(dn.id),   32'(e_id));
    chk({tag, ".src"},  32'(dn.src),  32'(e_src));
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("%s.wake%0d", tag, i), 32'(o_wake[i]), 32'(e_wake[i]));
      chk($sformatf("%s.dst%0d", tag, i),  32'(o_dst[i]),  32'(e_dst[i]));
      chk($sformatf("%s.err%0d", tag, i),  32'(o_err[i]),  32'(e_err[i]));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".sync"}, 32'(dn.sync), 0);
    chk({tag, ".pay"},  32'({dn.aggr, dn.id, dn.src}), 0);
    chk({tag, ".rr"},   32'(dut.rr_q), 0);
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("%s.port%0d", tag, i), 32'({o_wake[i], o_dst[i], o_err[i]}), 0);
    end
  endtask

  // One clock: predict registered outputs from the model, advance, compare,
  // then drop the single-cycle input pulses.
  task automatic tick(input string tag);
    bit found;
    int g, p, dd;
    bit empty;
    found = 1'b0;
    g = 0;
    for (int k = 0; k < NP; k++) begin
      if (!found && m_v[(m_rr + k) % NP]) begin
        found = 1'b1;
        g = (m_rr + k) % NP;
      end
    end
    e_sync = found;
    e_aggr = found ? m_a[g] : '0;
    e_id   = found ? m_i[g] : '0;
    e_src  = found ? DW'(g * (1 << SW) + int'(m_s[g])) : '0;
    p  = int'(d_dst) / (1 << SW);
    dd = int'(d_dst) % (1 << SW);
    for (int i = 0; i < NP; i++) begin
      empty = !m_v[i] || (found && g == i);
      e_err[i] = s_sync[i] && !empty;
      if (s_sync[i] && empty) begin
        m_v[i] = 1'b1;
        m_a[i] = s_aggr[i];
        m_i[i] = s_id[i];
        m_s[i] = s_src[i];
      end else if (found && g == i) begin
        m_v[i] = 1'b0;
      end
      e_wake[i] = d_wake && (p == i);
      e_dst[i]  = e_wake[i] ? SW'(dd) : '0;
      e_err[i]  = e_err[i] || (d_err && (p == i));
    end
    if (found) m_rr = (g + 1) % NP;
    @(posedge clk);
    #1;
    check_outputs(tag);
    s_sync = '0;
    d_wake = 1'b0;
    d_err  = 1'b0;
  endtask

  task automatic set_req(input int port, input logic [AW-1:0] a, input logic [IW-1:0] id,
                         input logic [SW-1:0] src);
    s_sync[port] = 1'b1;
    s_aggr[port] = a;
    s_id[port]   = id;
    s_src[port]  = src;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_zero(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int n1, e1;
    rst    = 1'b1;
    s_sync = '0;
    d_wake = 1'b0;
    d_err  = 1'b0;
    d_dst  = '0;
    a_wake = 1'b0;
    a_err  = 1'b0;
    a_dst  = '0;
    for (int i = 0; i < NP; i++) begin
      s_aggr[i] = '0;
      s_id[i]   = '0;
      s_src[i]  = '0;
    end
    model_reset();
    @(posedge clk);
    #1;
    check_zero("rst");
    rst = 1'b0;

    // Single request on port 2: two-cycle latency, src carries the port index
    set_req(2, 8'h01, 4'd3, 2'd1);
    tick("single.load");
    chk("single.early", 32'(dn.sync), 0);
    tick("single.out");
    chk("single.sync", 32'(dn.sync), 1);
    chk("single.id",   32'(dn.id), 3);
    chk("single.aggr", 32'(dn.aggr), 32'h01);
    chk("single.src",  32'(dn.src), 32'b1001);
    tick("single.idle");

    // Full contention after reset: drained 0,1,2,3 on consecutive cycles
    do_reset("rst2");
    for (int i = 0; i < NP; i++) set_req(i, AW'(8'h10 + i), IW'(i + 4), SW'(3 - i));
    tick("full.load");
    for (int i = 0; i < NP; i++) begin
      tick("full.drain");
      chk($sformatf("full.port%0d", i), 32'({dn.sync, dn.src[DW-1:SW]}), 32'(4 + i));
    end
    chk("full.rr", 32'(dut.rr_q), 0);
    tick("full.idle");

    // Overflow: port 1 re-syncs while occupied; port 0 keeps resyncing
    do_reset("rst3");
    n1 = 0;
    e1 = 0;
    set_req(0, 8'hA0, 4'd1, 2'd0);
    set_req(1, 8'h11, 4'd2, 2'd2);
    tick("ovf.a");
    set_req(0, 8'hA1, 4'd1, 2'd0);
    set_req(1, 8'h77, 4'd7, 2'd3);
    tick("ovf.b");
    e1 += int'(o_err[1]);
    for (int c = 0; c < 6; c++) begin
      if (c < 2) set_req(0, AW'(8'hB0 + c), 4'd1, 2'd0);
      tick("ovf.drain");
      e1 += int'(o_err[1]);
      if (dn.sync && dn.src[DW-1:SW] == 2'd1) begin
        n1++;
        chk("ovf.kept", 32'(dn.aggr), 32'h11);
      end
    end
    chk("ovf.fwd1", 32'(n1), 1);
    chk("ovf.err1", 32'(e1), 1);

    // Wake routing, concurrent with a grant
    set_req(2, 8'h5A, 4'd9, 2'd0);
    tick("wake.req");
    d_wake = 1'b1;
    d_dst  = {2'd3, 2'd2};
    tick("wake.go");
    chk("wake.p3", 32'({o_wake[3], o_dst[3]}), 32'b110);
    chk("wake.others", 32'({o_wake[0], o_wake[1], o_wake[2]}), 0);
    chk("wake.grant", 32'(dn.sync), 1);
    d_err = 1'b1;
    d_dst = {2'd1, 2'd0};
    tick("err.route");
    chk("err.p1", 32'(o_err), 32'b0010);

    // Out-of-range port on the wide-index instance is discarded
    a_wake = 1'b1;
    a_err  = 1'b1;
    a_dst  = {3'd5, 2'd1};
    @(posedge clk);
    #1;
    a_wake = 1'b0;
    a_err  = 1'b0;
    chk("aux.oor.wake", 32'(ao_wake), 0);
    chk("aux.oor.err",  32'(ao_err), 0);
    chk("aux.oor.dst",  32'({ao_dst[0], ao_dst[1], ao_dst[2], ao_dst[3]}), 0);
    a_wake = 1'b1;
    a_dst  = {3'd3, 2'd2};
    @(posedge clk);
    #1;
    a_wake = 1'b0;
    chk("aux.in.wake", 32'(ao_wake), 32'b1000);
    chk("aux.in.dst",  32'(ao_dst[3]), 2);
    chk("aux.mst", 32'({adn.sync, adn.aggr, adn.id, adn.src}), 0);

    // Randomized traffic against the model
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(0, 9) < 4)
          set_req(i, AW'($urandom), IW'($urandom), SW'($urandom));
      end
      d_wake = ($urandom_range(0, 9) < 3);
      d_err  = ($urandom_range(0, 9) < 2);
      d_dst  = DW'($urandom);
      tick("rand");
    end
    d_dst = '0;

    // Reset mid-drain with three slots still pending
    do_reset("rst4");
    for (int i = 0; i < NP; i++) set_req(i, AW'(8'hC0 + i), 4'd5, 2'd1);
    tick("mid.load");
    tick("mid.g0");
    #3;
    rst = 1'b1;
    #1;
    check_zero("mid.rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      tick("mid.quiet");
      chk("mid.nosync", 32'(dn.sync), 0);
    end
    set_req(1, 8'hE1, 4'd6, 2'd2);
    tick("mid.new.load");
    tick("mid.new.out");
    chk("mid.new", 32'({dn.sync, dn.aggr, dn.src}), 32'({1'b1, 8'hE1, 4'b0110}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
